// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped I/O block with three ports.
//   P1: signed display register, shown in decimal on a 4-digit
//       multiplexed 7-segment display.
//   P2: debounced pushbutton with a sticky press flag (write clears).
//   P3: synchronized switch inputs (read-only).
module io_port_ctrl #(
    parameter int           N              = 8,
    parameter int           DEB_CYCLES     = 250000,
    parameter int           REFRESH_CYCLES = 50000,
    parameter logic [N-1:0] P1_ADDR        = 8'hFD,
    parameter logic [N-1:0] P2_ADDR        = 8'hFE,
    parameter logic [N-1:0] P3_ADDR        = 8'hFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        Addr,
    input  logic signed [N-1:0] WriteData,
    input  logic                WE,
    output logic [N-1:0]        ReadData,
    input  logic                btn_raw,
    input  logic [N-1:0]        sw_raw,
    output logic [6:0]          seg,
    output logic [3:0]          an
);

    // Counter widths sized so that the terminal value (CYCLES-1) fits.
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

    localparam logic [N-1:0] C_TEN = N'(10);
    localparam logic [N-1:0] C_HUN = N'(100);

    // Segment patterns, {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Decimal digit to segment pattern; anything out of range is blank.
    function automatic logic [6:0] f_seg(input logic [N-1:0] v);
        logic [6:0] s;
        case (v)
            N'(0):   s = 7'h40;
            N'(1):   s = 7'h79;
            N'(2):   s = 7'h24;
            N'(3):   s = 7'h30;
            N'(4):   s = 7'h19;
            N'(5):   s = 7'h12;
            N'(6):   s = 7'h02;
            N'(7):   s = 7'h78;
            N'(8):   s = 7'h00;
            N'(9):   s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic signed [N-1:0] r_disp_reg;
    logic                r_btn_meta;
    logic                r_btn_sync;
    logic [N-1:0]        r_sw_meta;
    logic [N-1:0]        r_sw_sync;
    logic                r_btn_state;
    logic                r_press_flag;
    logic [DEB_W-1:0]    r_deb_cnt;
    logic [REF_W-1:0]    r_refresh_cnt;
    logic [1:0]          r_digit_idx;
    logic [6:0]          r_seg;
    logic [3:0]          r_an;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic         w_wr_p1;
    logic         w_wr_p2;
    logic         w_btn_differ;
    logic         w_deb_done;
    logic         w_btn_rise;
    logic [N-1:0] w_mag;
    logic [N-1:0] w_ones;
    logic [N-1:0] w_tens;
    logic [N-1:0] w_hund;
    logic         w_neg;
    logic         w_tens_blank;
    logic [6:0]   w_seg_next;
    logic [3:0]   w_an_next;

    assign w_wr_p1 = WE && (Addr == P1_ADDR);
    assign w_wr_p2 = WE && (Addr == P2_ADDR);

    // Display register: only writes to the display port land here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_reg <= '0;
        end else if (w_wr_p1) begin
            r_disp_reg <= WriteData;
        end
    end

    // Two-flop synchronizer for the pushbutton.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_btn_meta <= btn_raw;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Two-flop synchronizer per switch bit; bits are independent inputs.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sw_sync
            // Synchronize switch bit gi.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sw_meta[gi] <= 1'b0;
                    r_sw_sync[gi] <= 1'b0;
                end else begin
                    r_sw_meta[gi] <= sw_raw[gi];
                    r_sw_sync[gi] <= r_sw_meta[gi];
                end
            end
        end
    endgenerate

    // The accepted state flips on the DEB_CYCLES-th consecutive cycle of
    // disagreement; a single agreeing cycle restarts the count.
    assign w_btn_differ = (r_btn_sync != r_btn_state);
    assign w_deb_done   = w_btn_differ && (r_deb_cnt == DEB_LAST);
    assign w_btn_rise   = w_deb_done && r_btn_sync;

    // Debounce counter and accepted button state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt   <= '0;
            r_btn_state <= 1'b0;
        end else if (!w_btn_differ) begin
            r_deb_cnt <= '0;
        end else if (w_deb_done) begin
            r_deb_cnt   <= '0;
            r_btn_state <= r_btn_sync;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    // Sticky press flag; a new press beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press_flag <= 1'b0;
        end else if (w_btn_rise) begin
            r_press_flag <= 1'b1;
        end else if (w_wr_p2) begin
            r_press_flag <= 1'b0;
        end
    end

    // Combinational read mux; unmapped addresses read as zero.
    always_comb begin
        ReadData = '0;
        if (Addr == P1_ADDR) begin
            ReadData = r_disp_reg;
        end else if (Addr == P2_ADDR) begin
            ReadData = {{(N-2){1'b0}}, r_press_flag, r_btn_state};
        end else if (Addr == P3_ADDR) begin
            ReadData = r_sw_sync;
        end
    end

    // Refresh counter and digit index; index steps on counter wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= 2'd0;
        end else if (r_refresh_cnt == REF_LAST) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= r_digit_idx + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // Magnitude of the signed value; the most negative value maps to its
    // unsigned bit pattern, which is the correct magnitude.
    assign w_neg  = r_disp_reg[N-1];
    assign w_mag  = w_neg ? (~$unsigned(r_disp_reg) + N'(1)) : $unsigned(r_disp_reg);
    assign w_ones = w_mag % C_TEN;
    assign w_tens = (w_mag / C_TEN) % C_TEN;
    assign w_hund = (w_mag / C_HUN) % C_TEN;
    assign w_tens_blank = (w_hund == '0) && (w_tens == '0);

    // Select the pattern and enable for the digit currently being scanned.
    always_comb begin
        w_seg_next = SEG_BLANK;
        w_an_next  = 4'hF;
        case (r_digit_idx)
            2'd0: begin
                w_an_next  = 4'b1110;
                w_seg_next = f_seg(w_ones);
            end
            2'd1: begin
                w_an_next  = 4'b1101;
                w_seg_next = w_tens_blank ? SEG_BLANK : f_seg(w_tens);
            end
            2'd2: begin
                w_an_next  = 4'b1011;
                w_seg_next = (w_hund == '0) ? SEG_BLANK : f_seg(w_hund);
            end
            default: begin
                w_an_next  = 4'b0111;
                w_seg_next = w_neg ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

    // Registered display outputs, blanked while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Testbench for io_port_ctrl with short debounce/refresh periods.
module tb_io_port_ctrl;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        Addr = 8'h00;
    logic signed [7:0] WriteData = 8'sh00;
    logic              WE = 1'b0;
    logic [7:0]        ReadData;
    logic              btn_raw = 1'b0;
    logic [7:0]        sw_raw = 8'h00;
    logic [6:0]        seg;
    logic [3:0]        an;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } scan_t;

    scan_t      scan_q[$];
    logic [7:0] rd_q[$];

    // Expected segment patterns, {g,f,e,d,c,b,a} active-low.
    localparam logic [6:0] S0  = 7'h40;
    localparam logic [6:0] S1  = 7'h79;
    localparam logic [6:0] S2  = 7'h24;
    localparam logic [6:0] S3  = 7'h30;
    localparam logic [6:0] S7  = 7'h78;
    localparam logic [6:0] S8  = 7'h00;
    localparam logic [6:0] SBL = 7'h7F;
    localparam logic [6:0] SMI = 7'h3F;

    io_port_ctrl #(
        .N              (8),
        .DEB_CYCLES     (4),
        .REFRESH_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Addr      (Addr),
        .WriteData (WriteData),
        .WE        (WE),
        .ReadData  (ReadData),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // One bus write, driven from a negedge; returns on the following negedge.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        WE        = 1'b1;
        Addr      = a;
        WriteData = d;
        @(posedge clk);
        @(negedge clk);
        WE = 1'b0;
        $display("wr addr=%h data=%h", a, d);
    endtask

    task automatic push_scan(input logic [3:0] a, input logic [6:0] s);
        scan_t e;
        e.an  = a;
        e.seg = s;
        scan_q.push_back(e);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if (an !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_an: got %b required %b", an, 4'hF);
        end
        n_checks++;
        if (seg !== 7'h7F) begin
            n_fail++;
            $display("FAIL reset_seg: got %h required %h", seg, 7'h7F);
        end
        Addr = 8'hFD;
        #1;
        n_checks++;
        if (ReadData !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_disp: got %h required %h", ReadData, 8'h00);
        end
        Addr = 8'hFE;
        #1;
        n_checks++;
        if (ReadData !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_btn: got %h required %h", ReadData, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (an !== 4'b1110 || seg !== S0) begin
            n_fail++;
            $display("FAIL reset_first_digit: got an=%b seg=%h required an=1110 seg=%h", an, seg, S0);
        end
        $display("reset done");
    endtask

    task automatic test_write;
        scan_t e;
        int    waited;
        do_write(8'hFD, 8'hF3);
        n_checks++;
        if (ReadData !== 8'hF3) begin
            n_fail++;
            $display("FAIL write_readback: got %h required %h", ReadData, 8'hF3);
        end
        // -13: sign, blank hundreds, '1', '3'
        push_scan(4'b0111, SMI);
        push_scan(4'b1011, SBL);
        push_scan(4'b1101, S1);
        push_scan(4'b1110, S3);
        @(negedge clk);
        while (scan_q.size() > 0) begin
            e = scan_q.pop_front();
            waited = 0;
            while (an !== e.an && waited < 12) begin
                @(negedge clk);
                waited++;
            end
            n_checks++;
            if (an !== e.an) begin
                n_fail++;
                $display("FAIL write_scan_digit: an=%b never reached, required %b", an, e.an);
            end else if (seg !== e.seg) begin
                n_fail++;
                $display("FAIL write_scan_seg: an=%b got seg=%h required %h", an, seg, e.seg);
            end
            n_checks++;
            if ($countones(~an) != 1) begin
                n_fail++;
                $display("FAIL write_scan_onehot: got an=%b required one low bit", an);
            end
        end
        // A write to an unmapped address must not disturb the display port.
        do_write(8'h10, 8'h55);
        Addr = 8'hFD;
        #1;
        n_checks++;
        if (ReadData !== 8'hF3) begin
            n_fail++;
            $display("FAIL write_ignored: got %h required %h", ReadData, 8'hF3);
        end
    endtask

    task automatic test_switches;
        logic [7:0] exp_v;
        Addr   = 8'hFF;
        sw_raw = 8'hA5;
        rd_q.push_back(8'h00);
        rd_q.push_back(8'hA5);
        rd_q.push_back(8'hA5);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = rd_q.pop_front();
            n_checks++;
            if (ReadData !== exp_v) begin
                n_fail++;
                $display("FAIL switches_edge%0d: got %h required %h", k, ReadData, exp_v);
            end
        end
        Addr = 8'h10;
        #1;
        n_checks++;
        if (ReadData !== 8'h00) begin
            n_fail++;
            $display("FAIL unmapped_read: got %h required %h", ReadData, 8'h00);
        end
        $display("switches sw=%h checked", sw_raw);
    endtask

    task automatic test_bounce;
        logic [7:0] exp_v;
        Addr = 8'hFE;
        for (int k = 1; k <= 14; k++) begin
            btn_raw = (k == 4) ? 1'b0 : 1'b1;
            // Synchronized input settles high after edge 6; state follows 4 edges later.
            rd_q.push_back((k >= 10) ? 8'h03 : 8'h00);
            @(posedge clk);
            @(negedge clk);
            exp_v = rd_q.pop_front();
            n_checks++;
            if (ReadData !== exp_v) begin
                n_fail++;
                $display("FAIL bounce_edge%0d: got %h required %h", k, ReadData, exp_v);
            end
        end
        $display("bounce sequence done");
    endtask

    task automatic test_clear;
        Addr    = 8'hFE;
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (ReadData !== 8'h02) begin
            n_fail++;
            $display("FAIL clear_released: got %h required %h", ReadData, 8'h02);
        end
        do_write(8'hFE, 8'h00);
        n_checks++;
        if (ReadData !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_write: got %h required %h", ReadData, 8'h00);
        end
        // New press whose accepting edge coincides with a clearing write.
        btn_raw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            WE = (k == 6);
            @(posedge clk);
            @(negedge clk);
            WE = 1'b0;
            if (k == 5) begin
                n_checks++;
                if (ReadData !== 8'h00) begin
                    n_fail++;
                    $display("FAIL clear_pre_edge: got %h required %h", ReadData, 8'h00);
                end
            end
        end
        n_checks++;
        if (ReadData !== 8'h03) begin
            n_fail++;
            $display("FAIL clear_set_wins: got %h required %h", ReadData, 8'h03);
        end
        $display("clear/set collision done");
    endtask

    task automatic test_extremes;
        logic [7:0] vals [4];
        logic [6:0] exps [4][4];
        scan_t      e;
        int         waited;
        vals[0] = 8'h80; exps[0] = '{SMI, S1,  S2,  S8};
        vals[1] = 8'h7F; exps[1] = '{SBL, S1,  S2,  S7};
        vals[2] = 8'h00; exps[2] = '{SBL, SBL, SBL, S0};
        vals[3] = 8'h0A; exps[3] = '{SBL, SBL, S1,  S0};
        for (int v = 0; v < 4; v++) begin
            do_write(8'hFD, vals[v]);
            push_scan(4'b0111, exps[v][0]);
            push_scan(4'b1011, exps[v][1]);
            push_scan(4'b1101, exps[v][2]);
            push_scan(4'b1110, exps[v][3]);
            @(negedge clk);
            while (scan_q.size() > 0) begin
                e = scan_q.pop_front();
                waited = 0;
                while (an !== e.an && waited < 12) begin
                    @(negedge clk);
                    waited++;
                end
                n_checks++;
                if (an !== e.an) begin
                    n_fail++;
                    $display("FAIL extreme_%h_digit: an=%b never reached, required %b", vals[v], an, e.an);
                end else if (seg !== e.seg) begin
                    n_fail++;
                    $display("FAIL extreme_%h_seg: an=%b got seg=%h required %h", vals[v], an, seg, e.seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op;
        do_write(8'hFD, 8'h7F);
        Addr    = 8'hFD;
        btn_raw = 1'b0;
        repeat (8) @(negedge clk);
        btn_raw = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        #1;
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            n_fail++;
            $display("FAIL async_reset_display: got an=%b seg=%h required an=1111 seg=7f", an, seg);
        end
        n_checks++;
        if (ReadData !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_disp: got %h required %h", ReadData, 8'h00);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (an !== 4'b1110 || seg !== S0) begin
            n_fail++;
            $display("FAIL mid_reset_first_digit: got an=%b seg=%h required an=1110 seg=%h", an, seg, S0);
        end
        Addr = 8'hFE;
        repeat (8) @(negedge clk);
        n_checks++;
        if (ReadData !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_no_press: got %h required %h", ReadData, 8'h00);
        end
        $display("reset mid-operation done");
    endtask

    initial begin
        test_reset();
        test_write();
        test_switches();
        test_bounce();
        test_clear();
        test_extremes();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning data/address width.
REQ-002 SHALL have parameter DEB_CYCLES, default 250000, meaning consecutive stable cycles required to accept a button change.
REQ-003 SHALL have parameter REFRESH_CYCLES, default 50000, meaning clock cycles each display digit stays lit.
REQ-004 SHALL have parameters P1_ADDR = 8'hFD (display), P2_ADDR = 8'hFE (button) and P3_ADDR = 8'hFF (switches), meaning the port addresses.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port Addr, input, N, bus address from the data memory side.
REQ-008 SHALL have port WriteData, input, N, signed write data.
REQ-009 SHALL have port WE, input, 1, write enable.
REQ-010 SHALL have port ReadData, output, N, port read data.
REQ-011 SHALL have port btn_raw, input, 1, asynchronous pushbutton, high = pressed.
REQ-012 SHALL have port sw_raw, input, N, asynchronous switches.
REQ-013 SHALL have port seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
REQ-014 SHALL have port an, output, 4, digit enables, active-low; an[0] = rightmost digit.

Function
REQ-015 SHALL capture WriteData into an N-bit signed register disp_reg on a clock edge with WE=1 and Addr==P1_ADDR; all other writes are ignored except REQ-019.
REQ-016 SHALL pass btn_raw and sw_raw each through a 2-flop synchronizer before any other use.
REQ-017 SHALL hold a debounced btn_state that changes only after the synchronized button has differed from btn_state for DEB_CYCLES consecutive cycles; any single cycle of agreement resets the count to 0.
REQ-018 SHALL set a sticky press_flag on the cycle btn_state goes 0->1.
REQ-019 SHALL clear press_flag on a write to P2_ADDR; if a write coincides with a new rising edge, the set wins.
REQ-020 SHALL drive ReadData combinationally from Addr: P1_ADDR -> disp_reg; P2_ADDR -> {zeros, press_flag, btn_state}; P3_ADDR -> synchronized switches; any other address -> 0.
REQ-021 SHALL show disp_reg as signed decimal: digit 3 = '-' (only g lit) if negative, else blank; digits 2..0 = hundreds, tens and ones of |disp_reg| (-128 shows "-128"); leading zeros are blanked except the ones digit.
REQ-022 SHALL scan digits with a refresh counter (0..REFRESH_CYCLES-1) and a 2-bit digit index that advances 0->1->2->3->0 on counter wrap; exactly one an bit is low at a time.
REQ-023 SHALL register seg and an, so they update one cycle after the index changes, and a new disp_reg value appears on the next refreshed digit.
REQ-024 SHALL use hex-digit-free decimal encoding for 0-9, with blank = 7'h7F and '-' = 7'h3F.

Reset
REQ-025 SHALL, while rst_n=0, force: disp_reg=0, btn_state=0, press_flag=0, debounce count=0, synchronizers=0, refresh counter=0, digit index=0, seg=7'h7F and an=4'hF.
REQ-026 SHALL, on the first refresh after release, light digit 0 with "0".
REQ-027 SHALL, when reset is asserted mid-debounce or mid-scan, abandon the operation immediately with no pending press recorded.

Verification (DEB_CYCLES=4, REFRESH_CYCLES=2)
REQ-028 Write -> WE=1, Addr=FD, WriteData=8'hF3 -> ReadData(Addr=FD)=8'hF3; scan shows '-', blank, '1', '3' (an=0111 -> seg=3F; an=1110 -> seg=30 for 3).
REQ-029 Bounce -> btn_raw high 3 cycles, low 1, high 10 -> btn_state rises exactly 4 cycles after the synchronized input settles high; press_flag=1; ReadData(FE)=8'h03.
REQ-030 Clear -> write FE while press_flag=1 -> flag cleared next edge; a rising edge on the same cycle leaves flag=1.
REQ-031 Switches -> sw_raw=8'hA5 -> ReadData(FF)=8'hA5 from the 2nd clock edge on; unmapped Addr=8'h10 -> ReadData=0.
REQ-032 Extremes -> disp_reg=8'h80 shows "-128"; disp_reg=8'h7F shows " 127"; disp_reg=0 shows "   0".
REQ-033 Reset mid-scan -> rst_n low asynchronously -> an=F, seg=7F and disp_reg=0 without waiting for a clock edge.
